// File: rtl/hazard_sequencer_pkg.sv
// hazard_sequencer_pkg: state encodings, forward selects and write-mode constants for the hazard sequencer
package hazard_sequencer_pkg;

    localparam logic [1:0] HZ_RESET   = 2'd0;
    localparam logic [1:0] HZ_RUN     = 2'd1;
    localparam logic [1:0] HZ_MEMWAIT = 2'd2;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [2:0] NOREGWRITE = 3'b000;

    typedef enum logic [1:0] {
        S_RESET    = HZ_RESET,
        S_RUN      = HZ_RUN,
        S_MEM_WAIT = HZ_MEMWAIT
    } hz_state_t;

endpackage

// File: rtl/hazard_sequencer_if.sv
// hazard_sequencer_if: decoded per-stage control in, stall/flush/forward strobes out
interface hazard_sequencer_if;
    logic [4:0] Rs1D, Rs2D;
    logic [1:0] RegReadD;
    logic [4:0] Rs1E, Rs2E;
    logic [1:0] RegReadE;
    logic [4:0] RdE, RdM, RdW;
    logic [2:0] RegWriteE, RegWriteM, RegWriteW;
    logic       MemToRegE, JalD, JalrE, BranchE, DCacheMiss;
    logic       StallF, FlushF, StallD, FlushD, StallE, FlushE, StallM, FlushM, StallW, FlushW;
    logic [1:0] Forward1E, Forward2E;
    logic       MemTimeoutErr;

    modport master (
        output Rs1D, Rs2D, RegReadD, Rs1E, Rs2E, RegReadE, RdE, RdM, RdW,
               RegWriteE, RegWriteM, RegWriteW, MemToRegE, JalD, JalrE, BranchE, DCacheMiss,
        input  StallF, FlushF, StallD, FlushD, StallE, FlushE, StallM, FlushM, StallW, FlushW,
               Forward1E, Forward2E, MemTimeoutErr
    );

    modport slave (
        input  Rs1D, Rs2D, RegReadD, Rs1E, Rs2E, RegReadE, RdE, RdM, RdW,
               RegWriteE, RegWriteM, RegWriteW, MemToRegE, JalD, JalrE, BranchE, DCacheMiss,
        output StallF, FlushF, StallD, FlushD, StallE, FlushE, StallM, FlushM, StallW, FlushW,
               Forward1E, Forward2E, MemTimeoutErr
    );
endinterface

// File: rtl/hazard_sequencer_forward_select.sv
// forward_select: picks the EX operand source, MEM result over WB result over register file
module forward_select
    import hazard_sequencer_pkg::*;
(
    input  logic [4:0] rs_i,
    input  logic       use_i,
    input  logic [4:0] rd_m_i,
    input  logic [2:0] we_m_i,
    input  logic [4:0] rd_w_i,
    input  logic [2:0] we_w_i,
    output logic [1:0] sel_o
);
    logic hit_m, hit_w;

    assign hit_m = use_i && we_m_i != NOREGWRITE && rd_m_i != 5'd0 && rd_m_i == rs_i;
    assign hit_w = use_i && we_w_i != NOREGWRITE && rd_w_i != 5'd0 && rd_w_i == rs_i;
    assign sel_o = hit_m ? FWD_MEM : hit_w ? FWD_WB : FWD_RF;
endmodule

// File: rtl/hazard_sequencer.sv
// hazard_sequencer: stall/flush/forward control for the 5-stage core; HAZARD_PERF_CNT_EN adds performance counters
module hazard_sequencer
    import hazard_sequencer_pkg::*;
#(
    parameter int unsigned RESET_FLUSH_CYCLES = 2,
    parameter int unsigned MEM_TIMEOUT        = 64,
    parameter int unsigned CNT_W              = 32
) (
    input  logic                CPU_CLK,
    input  logic                CPU_RST,
    hazard_sequencer_if.slave   hz
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]    StallCycles,
    output logic [CNT_W-1:0]    FlushEvents,
    output logic [CNT_W-1:0]    MemWaitCycles
`endif
);
    localparam logic [31:0] RST_LAST = RESET_FLUSH_CYCLES == 0 ? 32'd0 : 32'(RESET_FLUSH_CYCLES - 1);
    localparam logic [31:0] TMO      = 32'(MEM_TIMEOUT);

    hz_state_t   st_q, st_d;
    logic [31:0] cnt_q, cnt_d;
    logic        err_q, err_d;
    logic [4:0]  stall_v, flush_v;
    logic [1:0]  fwd1, fwd2;
    logic        load_use;

    assign load_use = hz.MemToRegE && hz.RdE != 5'd0 &&
                      ((hz.RegReadD[1] && hz.RdE == hz.Rs1D) || (hz.RegReadD[0] && hz.RdE == hz.Rs2D));

    // Stage strobes {F,D,E,M,W}: reset flush, then miss > redirect > load-use > jal
    always_comb begin
        stall_v = '0;
        flush_v = '0;
        if (CPU_RST || st_q == S_RESET) flush_v = '1;
        else if (hz.DCacheMiss) begin
            stall_v = 5'b11110;
            flush_v = 5'b00001;
        end
        else if (hz.BranchE || hz.JalrE) flush_v = 5'b01100;
        else if (load_use) begin
            stall_v = 5'b11000;
            flush_v = 5'b00100;
        end
        else if (hz.JalD) flush_v = 5'b01000;
    end

    assign {hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.StallW} = stall_v;
    assign {hz.FlushF, hz.FlushD, hz.FlushE, hz.FlushM, hz.FlushW} = flush_v;
    assign hz.MemTimeoutErr = err_q && !CPU_RST;

    forward_select u_fwd1 (
        .rs_i(hz.Rs1E), .use_i(hz.RegReadE[1]),
        .rd_m_i(hz.RdM), .we_m_i(hz.RegWriteM),
        .rd_w_i(hz.RdW), .we_w_i(hz.RegWriteW),
        .sel_o(fwd1)
    );

    forward_select u_fwd2 (
        .rs_i(hz.Rs2E), .use_i(hz.RegReadE[0]),
        .rd_m_i(hz.RdM), .we_m_i(hz.RegWriteM),
        .rd_w_i(hz.RdW), .we_w_i(hz.RegWriteW),
        .sel_o(fwd2)
    );

    assign hz.Forward1E = CPU_RST ? FWD_RF : fwd1;
    assign hz.Forward2E = CPU_RST ? FWD_RF : fwd2;

    // Phase sequencing; one counter serves both the reset flush and the memory-wait timeout
    always_comb begin
        st_d  = st_q;
        cnt_d = cnt_q;
        case (st_q)
            S_RESET: begin
                st_d  = cnt_q >= RST_LAST ? S_RUN : S_RESET;
                cnt_d = cnt_q >= RST_LAST ? 32'd0 : cnt_q + 32'd1;
            end
            S_RUN: if (hz.DCacheMiss) begin
                st_d  = S_MEM_WAIT;
                cnt_d = 32'd1;
            end
            S_MEM_WAIT: if (hz.DCacheMiss) cnt_d = cnt_q >= TMO ? cnt_q : cnt_q + 32'd1;
            else begin
                st_d  = S_RUN;
                cnt_d = 32'd0;
            end
            default: begin
                st_d  = S_RESET;
                cnt_d = 32'd0;
            end
        endcase
        err_d = err_q || (st_d == S_MEM_WAIT && cnt_d >= TMO);
    end

    // State, counter and sticky timeout flag
    always_ff @(posedge CPU_CLK) begin
        if (CPU_RST) begin
            st_q  <= S_RESET;
            cnt_q <= 32'd0;
            err_q <= 1'b0;
        end else begin
            st_q  <= st_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q, wait_cnt_q;

    // Free-running wrap-around event counters
    always_ff @(posedge CPU_CLK) begin
        if (CPU_RST) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            wait_cnt_q  <= '0;
        end else begin
            if (stall_v[4]) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (st_q == S_RUN && flush_v[3]) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            if (st_q == S_MEM_WAIT) wait_cnt_q <= wait_cnt_q + CNT_W'(1);
        end
    end

    assign StallCycles   = stall_cnt_q;
    assign FlushEvents   = flush_cnt_q;
    assign MemWaitCycles = wait_cnt_q;
`endif
endmodule
